// File: rtl/int_mult_54x54.sv
// Pipelined 54x54 -> 108-bit integer multiplier with a valid/tag side-band and an in-flight counter.
// Define INT_MULT_SIGNED_EN for two's-complement operands and product; the default build is unsigned.
module int_mult_54x54 #(
  parameter  int LATENCY = 3,
  parameter  int TAG_W   = 4,
  localparam int CNT_W   = 2 + $clog2(LATENCY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [53:0]      mult_a,
  input  logic [53:0]      mult_b,
  output logic [107:0]     int_mult_result,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] inflight
);

`ifdef INT_MULT_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  // S1 operands, S2 partial products, S3 onwards result delay line
  logic [53:0]      a_q, b_q;
  logic [53:0]      a_hi_x, a_lo_x, b_hi_x, b_lo_x;
  logic [53:0]      hh_d, hl_d, lh_d, ll_d;
  logic [53:0]      hh_q, hl_q, lh_q, ll_q;
  logic [54:0]      mid_d;
  logic [107:0]     sum_d;
  logic [107:0]     res_q [LATENCY-2];
  logic             vld_q [LATENCY];
  logic [TAG_W-1:0] tag_q [LATENCY];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Each 27-bit half is widened to 54 bits so every partial product is exact modulo 2^54;
  // only the high halves carry a sign, and only in the signed build.
  assign a_hi_x = {{27{SignedEn & a_q[53]}}, a_q[53:27]};
  assign b_hi_x = {{27{SignedEn & b_q[53]}}, b_q[53:27]};
  assign a_lo_x = {27'b0, a_q[26:0]};
  assign b_lo_x = {27'b0, b_q[26:0]};

  assign hh_d = a_hi_x * b_hi_x;
  assign hl_d = a_hi_x * b_lo_x;
  assign lh_d = a_lo_x * b_hi_x;
  assign ll_d = a_lo_x * b_lo_x;

  // hl+lh needs one extra bit; the 55-bit sum is then extended according to the operand signedness.
  assign mid_d = {SignedEn & hl_q[53], hl_q} + {SignedEn & lh_q[53], lh_q};
  assign sum_d = {hh_q, 54'b0}
               + {{26{SignedEn & mid_d[54]}}, mid_d, 27'b0}
               + {54'b0, ll_q};

  // NOTE: always_comb assigns a default first so no path leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && !out_valid)      cnt_d = cnt_q + CNT_W'(1);
    else if (!in_valid && out_valid) cnt_d = cnt_q - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      hh_q  <= '0;
      hl_q  <= '0;
      lh_q  <= '0;
      ll_q  <= '0;
      cnt_q <= '0;
      // NOTE: these arrays are pipeline flops, not RAM; they are reset so in-flight work is discarded.
      for (int i = 0; i < LATENCY - 2; i++) res_q[i] <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      a_q      <= mult_a;
      b_q      <= mult_b;
      hh_q     <= hh_d;
      hl_q     <= hl_d;
      lh_q     <= lh_d;
      ll_q     <= ll_d;
      res_q[0] <= sum_d;
      for (int i = 1; i < LATENCY - 2; i++) res_q[i] <= res_q[i-1];
      vld_q[0] <= in_valid;
      tag_q[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      cnt_q <= cnt_d;
    end
  end

  assign int_mult_result = res_q[LATENCY-3];
  assign out_valid       = vld_q[LATENCY-1];
  assign out_tag         = tag_q[LATENCY-1];
  assign inflight        = cnt_q;

endmodule

// File: tb/tb_int_mult_54x54.sv
// Self-checking bench for int_mult_54x54: directed scenarios plus a randomized stream
// compared against a history-queue reference model of the multiplier.
module tb_int_mult_54x54;
  localparam int LAT   = 3;
  localparam int TAG_W = 4;
  localparam int CNT_W = 2 + $clog2(LAT);
  localparam logic [53:0] MAX54 = 54'h3F_FFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [53:0]      mult_a = '0;
  logic [53:0]      mult_b = '0;
  logic [107:0]     int_mult_result;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] inflight;

  int n_checks = 0;
  int n_fail   = 0;

  // Every input sampled since the last reset release, oldest first
  logic [53:0]      q_a[$];
  logic [53:0]      q_b[$];
  logic             q_v[$];
  logic [TAG_W-1:0] q_t[$];

  int_mult_54x54 #(.LATENCY(LAT), .TAG_W(TAG_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_tag          (in_tag),
    .mult_a          (mult_a),
    .mult_b          (mult_b),
    .int_mult_result (int_mult_result),
    .out_valid       (out_valid),
    .out_tag         (out_tag),
    .inflight        (inflight)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [107:0] model_prod(input logic [53:0] a, input logic [53:0] b);
    logic [107:0] ea, eb;
`ifdef INT_MULT_SIGNED_EN
    ea = {{54{a[53]}}, a};
    eb = {{54{b[53]}}, b};
`else
    ea = {54'b0, a};
    eb = {54'b0, b};
`endif
    return ea * eb;
  endfunction

  // The entry visible at the outputs now was sampled LAT samples before the one just driven.
  function automatic int out_idx();
    return q_a.size() - 1 - LAT;
  endfunction

  function automatic logic [107:0] exp_result();
    int i = out_idx();
    if (i < 0) return '0;
    return model_prod(q_a[i], q_b[i]);
  endfunction

  function automatic logic exp_valid();
    int i = out_idx();
    if (i < 0) return 1'b0;
    return q_v[i];
  endfunction

  function automatic logic [TAG_W-1:0] exp_tag();
    int i = out_idx();
    if (i < 0) return '0;
    return q_t[i];
  endfunction

  // Valid requests already sampled whose results are still on their way or on the outputs now
  function automatic logic [CNT_W-1:0] exp_inflight();
    int n = 0;
    for (int k = q_a.size() - 1 - LAT; k <= q_a.size() - 2; k++)
      if (k >= 0 && q_v[k]) n++;
    return CNT_W'(n);
  endfunction

  function automatic logic [53:0] rand54();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return MAX54;
      1:       return '0;
      2:       return 54'h20_0000_0000_0000;
      default: return r[53:0];
    endcase
  endfunction

  task automatic drive(input logic v, input logic [TAG_W-1:0] t, input logic [53:0] a, input logic [53:0] b);
    @(negedge clk);
    in_valid = v;
    in_tag   = t;
    mult_a   = a;
    mult_b   = b;
    q_v.push_back(v);
    q_t.push_back(t);
    q_a.push_back(a);
    q_b.push_back(b);
  endtask

  task automatic drain();
    repeat (LAT + 1) drive(1'b0, '0, '0, '0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_tag   = '0;
    mult_a   = rand54();
    mult_b   = rand54();
    q_a.delete(); q_b.delete(); q_v.delete(); q_t.delete();
    q_v.push_back(in_valid);
    q_t.push_back(in_tag);
    q_a.push_back(mult_a);
    q_b.push_back(mult_b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (int_mult_result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", int_mult_result); end
    n_checks++; if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_tag !== '0)         begin n_fail++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    n_checks++; if (inflight !== '0)        begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    release_reset();
  endtask

  task automatic test_simple();
    logic [107:0] want;
    drain();
    for (int k = 0; k < 6; k++) begin
      if (k == 0) drive(1'b1, 4'h3, 54'd3, 54'd5);
      else        drive(1'b0, '0, '0, '0);
      want = (k == 3) ? 108'd15 : 108'd0;
      n_checks++; if (int_mult_result !== want) begin n_fail++; $display("FAIL simple_result k=%0d: got %0d want %0d", k, int_mult_result, want); end
      n_checks++; if (out_valid !== (k == 3))   begin n_fail++; $display("FAIL simple_valid k=%0d: got %b want %b", k, out_valid, (k == 3)); end
    end
  endtask

  task automatic test_max();
    logic [107:0] want;
`ifdef INT_MULT_SIGNED_EN
    want = 108'd1;
`else
    want = 108'hFFF_FFFF_FFFF_FF80_0000_0000_0001;
`endif
    drain();
    drive(1'b1, 4'hA, MAX54, MAX54);
    repeat (LAT) drive(1'b0, '0, '0, '0);
    n_checks++; if (int_mult_result !== want) begin n_fail++; $display("FAIL max_result: got %h want %h", int_mult_result, want); end
    n_checks++; if (out_tag !== 4'hA)         begin n_fail++; $display("FAIL max_tag: got %h want a", out_tag); end
  endtask

  task automatic test_ungated();
    drain();
    drive(1'b0, 4'h5, 54'd7, 54'd9);
    repeat (LAT) drive(1'b0, '0, '0, '0);
    n_checks++; if (int_mult_result !== 108'd63) begin n_fail++; $display("FAIL ungated_result: got %0d want 63", int_mult_result); end
    n_checks++; if (out_valid !== 1'b0)          begin n_fail++; $display("FAIL ungated_valid: got %b want 0", out_valid); end
    n_checks++; if (inflight !== '0)             begin n_fail++; $display("FAIL ungated_inflight: got %0d want 0", inflight); end
  endtask

  task automatic test_signedness();
    logic [107:0] want;
`ifdef INT_MULT_SIGNED_EN
    want = 108'hFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
`else
    want = 108'h7F_FFFF_FFFF_FFFE;
`endif
    drain();
    drive(1'b1, 4'h6, MAX54, 54'd2);
    repeat (LAT) drive(1'b0, '0, '0, '0);
    n_checks++; if (int_mult_result !== want) begin n_fail++; $display("FAIL sign_result: got %h want %h", int_mult_result, want); end
  endtask

  task automatic test_back_to_back();
    int next_tag = 0;
    int want_cnt;
    drain();
    for (int k = 0; k < 12; k++) begin
      if (k < 8) drive(1'b1, TAG_W'(k), 54'(k), 54'(k + 1));
      else       drive(1'b0, '0, '0, '0);
      want_cnt = (k <= 8) ? ((k < 3) ? k : 3) : (11 - k);
      n_checks++; if (inflight !== CNT_W'(want_cnt)) begin n_fail++; $display("FAIL b2b_inflight k=%0d: got %0d want %0d", k, inflight, want_cnt); end
      if (out_valid) begin
        n_checks++; if (out_tag !== TAG_W'(next_tag)) begin n_fail++; $display("FAIL b2b_tag: got %0d want %0d", out_tag, next_tag); end
        n_checks++; if (int_mult_result !== 108'(next_tag * (next_tag + 1))) begin
          n_fail++; $display("FAIL b2b_result tag=%0d: got %0d want %0d", next_tag, int_mult_result, next_tag * (next_tag + 1));
        end
        next_tag++;
      end
    end
    n_checks++; if (next_tag != 8) begin n_fail++; $display("FAIL b2b_count: got %0d results want 8", next_tag); end
  endtask

  task automatic test_reset_mid();
    drain();
    for (int k = 0; k < 3; k++) drive(1'b1, TAG_W'(k + 9), rand54(), rand54());
    n_checks++; if (inflight !== CNT_W'(2)) begin n_fail++; $display("FAIL mid_pre_inflight: got %0d want 2", inflight); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (inflight !== '0)        begin n_fail++; $display("FAIL mid_async_inflight: got %0d want 0", inflight); end
    n_checks++; if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
    n_checks++; if (int_mult_result !== '0) begin n_fail++; $display("FAIL mid_async_result: got %h want 0", int_mult_result); end
    n_checks++; if (out_tag !== '0)         begin n_fail++; $display("FAIL mid_async_tag: got %h want 0", out_tag); end
    @(posedge clk);
    release_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, TAG_W'($urandom), rand54(), rand54());
      n_checks++; if (out_valid !== 1'b0)             begin n_fail++; $display("FAIL mid_post_valid k=%0d: got %b want 0", k, out_valid); end
      n_checks++; if (inflight !== '0)                begin n_fail++; $display("FAIL mid_post_inflight k=%0d: got %0d want 0", k, inflight); end
      n_checks++; if (int_mult_result !== exp_result()) begin n_fail++; $display("FAIL mid_post_result k=%0d: got %h want %h", k, int_mult_result, exp_result()); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), TAG_W'($urandom), rand54(), rand54());
      n_checks++; if (int_mult_result !== exp_result()) begin n_fail++; $display("FAIL rand_result k=%0d: got %h want %h", k, int_mult_result, exp_result()); end
      n_checks++; if (out_valid !== exp_valid())        begin n_fail++; $display("FAIL rand_valid k=%0d: got %b want %b", k, out_valid, exp_valid()); end
      n_checks++; if (out_tag !== exp_tag())            begin n_fail++; $display("FAIL rand_tag k=%0d: got %h want %h", k, out_tag, exp_tag()); end
      n_checks++; if (inflight !== exp_inflight())      begin n_fail++; $display("FAIL rand_inflight k=%0d: got %0d want %0d", k, inflight, exp_inflight()); end
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_max();
    test_ungated();
    test_signedness();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
